// File: rtl/dac_write_scheduler.sv
// dac_write_scheduler: per-slave shadow words launched one at a time, round-robin.
// Optional WAIT timeout abort is compiled in when DAC_WR_TIMEOUT_EN is defined.
module dac_write_scheduler #(
  parameter int SPI_SLAVES     = 2,
  parameter int SPI_LENGTH     = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [$clog2(SPI_SLAVES)-1:0]    wr_slave,
  input  logic [SPI_LENGTH-1:0]            wr_data,
  output logic [SPI_SLAVES-1:0]            new_reg,
  output logic [SPI_SLAVES*SPI_LENGTH-1:0] spi_data,
  input  logic                             bLDAC,
  output logic [SPI_SLAVES-1:0]            pending,
  output logic                             busy,
  output logic                             done,
  output logic                             timeout_err
);

  localparam int SW  = $clog2(SPI_SLAVES);
  localparam int SWP = SW + 1;
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [SW:0] NS = SWP'(SPI_SLAVES);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    GAP
  } state_t;

  state_t state, state_nx;

  logic [SW-1:0]         cur;
  logic [SW-1:0]         rr_ptr;
  logic [SW-1:0]         pick;
  logic                  pick_vld;
  logic [SW:0]           sum;
  logic                  bLDAC_q;
  logic                  rise;
  logic                  wr_ok;
  logic                  gap_last;
  logic                  to_hit;
  logic                  done_nx;
  logic                  to_nx;
  logic [GW-1:0]         gap_cnt;
  logic [SPI_SLAVES-1:0] pending_nx;
  logic [SPI_LENGTH-1:0] shadow [SPI_SLAVES];
  logic [SPI_LENGTH-1:0] live   [SPI_SLAVES];

  assign rise     = bLDAC & ~bLDAC_q;
  assign wr_ok    = wr_en && ({1'b0, wr_slave} < NS);
  assign gap_last = (int'(gap_cnt) == GAP_CYCLES - 1);
  assign busy     = (state != IDLE);

  for (genvar k = 0; k < SPI_SLAVES; k++) begin : g_live
    assign spi_data[k*SPI_LENGTH +: SPI_LENGTH] = live[k];
  end

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    sum      = '0;
    for (int i = SPI_SLAVES - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + SWP'(i);
      if (sum >= NS) sum = sum - NS;
      if (pending[sum[SW-1:0]]) begin
        pick     = sum[SW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  // A write landing on cur in the LAUNCH cycle re-arms it.
  always_comb begin
    pending_nx = pending;
    if (state == LAUNCH) pending_nx[cur] = 1'b0;
    if (wr_ok) pending_nx[wr_slave] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    new_reg  = '0;
    done_nx  = 1'b0;
    to_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_vld) state_nx = LAUNCH;
      end
      LAUNCH: begin
        new_reg[cur] = 1'b1;
        state_nx     = WAIT;
      end
      WAIT: begin
        if (rise) begin
          done_nx  = 1'b1;
          state_nx = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else if (to_hit) begin
          to_nx    = 1'b1;
          state_nx = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_last) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cur     <= '0;
      rr_ptr  <= '0;
      bLDAC_q <= 1'b1;
      pending <= '0;
      done    <= 1'b0;
      gap_cnt <= '0;
      for (int k = 0; k < SPI_SLAVES; k++) begin
        shadow[k] <= '0;
        live[k]   <= '0;
      end
    end else begin
      state   <= state_nx;
      bLDAC_q <= bLDAC;
      pending <= pending_nx;
      done    <= done_nx;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (state == IDLE && pick_vld) cur <= pick;
      if (state == LAUNCH) begin
        live[cur] <= shadow[cur];
        rr_ptr    <= (cur == SW'(SPI_SLAVES - 1)) ? '0 : cur + 1'b1;
      end
      if (wr_ok) shadow[wr_slave] <= wr_data;
    end
  end

`ifdef DAC_WR_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] wait_cnt;
  logic          to_q;

  assign to_hit      = (state == WAIT) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = to_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      to_q     <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      to_q     <= to_nx;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
